// File: rtl/mmio_uart_tx_pkg.sv
// Shared address map, status layout and FSM encoding for mmio_uart_tx.
// MMIO_UART_TX_PARITY_EN adds the PARITY state and the parity helper.
package mmio_uart_tx_pkg;

  localparam logic [31:0] UART_TX_DATA_ADDRESS   = 32'h0000_2000;
  localparam logic [31:0] UART_TX_STATUS_ADDRESS = 32'h0000_2004;

  localparam int UART_STATUS_BUSY_BIT     = 0;
  localparam int UART_STATUS_FULL_BIT     = 1;
  localparam int UART_STATUS_OVERFLOW_BIT = 2;
  localparam int UART_STATUS_COUNT_LSB    = 8;
  localparam int UART_STATUS_COUNT_W      = 4;

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  // Even parity: the transmitted bit makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// byte_fifo: synchronous FIFO with power-of-two depth and an occupancy count.
// A push while full or a pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == COUNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Full is judged before the edge, so a pop in the same cycle cannot rescue a push.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte stores are queued in byte_fifo and sent as 8N1 frames.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          CLOCKS_PER_BIT  = 104,
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter logic [31:0] DATA_ADDRESS    = UART_TX_DATA_ADDRESS,
  parameter logic [31:0] STATUS_ADDRESS  = UART_TX_STATUS_ADDRESS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        store_strobe,
  input  logic [31:0] access_address,
  input  logic [31:0] write_data,
  output logic [31:0] status_word,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int                BAUD_W    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BAUD_W-1:0]     w_baud_next;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_bit_idx_next;
  logic [7:0]            r_shift;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  r_busy;
  logic                  r_overflow;

  logic                  w_is_data_addr;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_clear;
  logic                  w_pop;
  logic                  w_bit_end;
  logic                  w_last_data;
  logic [7:0]            w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic [FIFO_DEPTH_LOG2:0] w_count_next;
  logic                  w_unused_wdata;

  assign w_unused_wdata = ^write_data[31:8];

  assign w_is_data_addr = store_strobe && (access_address == DATA_ADDRESS);
  assign w_push         = w_is_data_addr && !w_full;
  assign w_drop         = w_is_data_addr && w_full;
  assign w_clear        = store_strobe && (access_address == STATUS_ADDRESS);

  byte_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (write_data[7:0]),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Occupancy after this edge, used so tx_busy reflects the state being entered.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = w_count + 1'b1;
      2'b01:   w_count_next = w_count - 1'b1;
      default: w_count_next = w_count;
    endcase
  end

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_last_data = (r_bit_idx == 3'd7);

  // State register plus the registered line, counters and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != ST_IDLE) || (w_count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_shift <= w_head;
  end

  // A full-drop and a clear in one cycle leave the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_clear) begin
      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_next = ST_START;
      ST_START: if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && w_last_data) begin
`ifdef MMIO_UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
`endif
      ST_STOP:  if (w_bit_end) w_state_next = w_empty ? ST_IDLE : ST_START;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop          = 1'b0;
    w_baud_next    = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_tx_next = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_bit_idx_next = '0;
          w_tx_next      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (w_last_data) begin
`ifdef MMIO_UART_TX_PARITY_EN
            w_tx_next = even_parity(r_shift);
`else
            w_tx_next = 1'b1;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[r_bit_idx + 3'd1];
          end
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_tx_next = 1'b1;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_tx_next = 1'b0;
          end else begin
            w_tx_next = 1'b1;
          end
        end
      end
      default: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
      end
    endcase
  end

  always_comb begin
    status_word                                   = '0;
    status_word[UART_STATUS_BUSY_BIT]             = r_busy;
    status_word[UART_STATUS_FULL_BIT]             = w_full;
    status_word[UART_STATUS_OVERFLOW_BIT]         = r_overflow;
    status_word[UART_STATUS_COUNT_LSB +: UART_STATUS_COUNT_W] = UART_STATUS_COUNT_W'(w_count);
  end

  assign uart_tx = r_tx;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed steps plus randomized bursts
// compared against a frame-level model of the serial line and the status word.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int          FRAME_CYC = FRAME_BITS * CPB;
  localparam logic [31:0] A_DATA    = 32'h0000_2000;
  localparam logic [31:0] A_STAT    = 32'h0000_2004;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        store_strobe = 1'b0;
  logic [31:0] access_address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] status_word;
  logic        uart_tx;
  logic        tx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] bb [5];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLOCKS_PER_BIT  (CPB),
    .FIFO_DEPTH_LOG2 (DL2),
    .DATA_ADDRESS    (A_DATA),
    .STATUS_ADDRESS  (A_STAT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .store_strobe   (store_strobe),
    .access_address (access_address),
    .write_data     (write_data),
    .status_word    (status_word),
    .uart_tx        (uart_tx),
    .tx_busy        (tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Move to 1 time unit after the n-th following rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    store_strobe   = 1'b1;
    access_address = addr;
    write_data     = data;
    step(1);
    store_strobe   = 1'b0;
    access_address = '0;
  endtask

  // Line level of cell k of a frame carrying byte b: start, LSB-first data, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FRAME_BITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Sends n bytes from bb (first one at relative edge 0), optionally interleaved with
  // random non-data stores, and checks line and status every cycle against the model.
  task automatic run_burst(input int n, input bit rand_gaps);
    bit          s_stb  [16];
    logic [31:0] s_addr [16];
    logic [31:0] s_data [16];
    int          dpos   [5];
    int          slots;
    int          gap;
    int          last_k;
    slots = 0;
    for (int i = 0; i < n; i++) begin
      dpos[i]       = slots;
      s_stb[slots]  = 1'b1;
      s_addr[slots] = A_DATA;
      s_data[slots] = ($urandom() & 32'hFFFF_FF00) | {24'h0, bb[i]};
      slots++;
      gap = rand_gaps ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gap; g++) begin
        s_stb[slots]  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       s_addr[slots] = A_STAT;
          1:       s_addr[slots] = 32'h0000_2008;
          2:       s_addr[slots] = 32'h0000_1FFC;
          default: s_addr[slots] = 32'h0001_0000 + ($urandom() & 32'h0000_FFFC);
        endcase
        s_data[slots] = $urandom();
        slots++;
      end
    end
    last_k = 1 + n * FRAME_CYC + 3;
    for (int k = 0; k <= last_k; k++) begin
      int pushed;
      int started;
      int t;
      int cnt;
      logic exp_tx;
      logic [31:0] es;
      if (k < slots) begin
        store_strobe   = s_stb[k];
        access_address = s_addr[k];
        write_data     = s_data[k];
      end else begin
        store_strobe   = 1'b0;
        access_address = '0;
      end
      step(1);
      pushed = 0;
      for (int i = 0; i < n; i++) if (dpos[i] <= k) pushed++;
      started = 0;
      for (int f = 0; f < n; f++) if (1 + f * FRAME_CYC <= k) started++;
      cnt = pushed - started;
      t = k - 1;
      exp_tx = 1'b1;
      if (t >= 0 && (t / FRAME_CYC) < n)
        exp_tx = frame_bit(bb[t / FRAME_CYC], (t % FRAME_CYC) / CPB);
      es     = '0;
      es[0]  = (k < 1 + n * FRAME_CYC);
      es[1]  = (cnt == DEPTH);
      es[11:8] = 4'(cnt);
      check("burst_tx", {31'b0, uart_tx}, {31'b0, exp_tx});
      check("burst_status", status_word, es);
    end
    store_strobe   = 1'b0;
    access_address = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   falls;
    int   guard;
    int   lows;
    int   busies;
    logic prev;

    // Reset state
    step(2);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_status", status_word, 32'd0);
    reset_n = 1'b1;
    step(2);

    // Single byte A5: start at N+1, mid-bit samples, busy drops at N+1+frame
    store(A_DATA, 32'h0000_00A5);
    step(1);
    check("single_start_fall", {31'b0, uart_tx}, 32'd0);
    step(2);
    for (int j = 0; j < FRAME_BITS; j++) begin
      check("single_bit", {31'b0, uart_tx}, {31'b0, frame_bit(8'hA5, j)});
      if (j < FRAME_BITS - 1) step(4);
    end
    step(1);
    check("single_busy_hold", {31'b0, tx_busy}, 32'd1);
    step(1);
    check("single_busy_drop", {31'b0, tx_busy}, 32'd0);
    check("single_idle_tx", {31'b0, uart_tx}, 32'd1);
    step(3);

    // Back-to-back 01, 02 on consecutive cycles
    bb[0] = 8'h01;
    bb[1] = 8'h02;
    run_burst(2, 1'b0);
    step(2);

    // Randomized bursts with interleaved stores to other addresses
    repeat (3) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < 5; i++) bb[i] = 8'($urandom());
      run_burst(n, 1'b1);
      step($urandom_range(1, 4));
    end

    // 8'h07: parity cell is 1 when parity is built in
    bb[0] = 8'h07;
    run_burst(1, 1'b0);
    step(2);

    // Overflow: six stores while the first frame is in flight
    prev  = uart_tx;
    falls = 0;
    for (int i = 0; i < 6; i++) begin
      store(A_DATA, 32'h0000_00FE);
      if (prev && !uart_tx) falls++;
      prev = uart_tx;
    end
    check("ovf_status", status_word, 32'h0000_0407);
    store(A_STAT, $urandom());
    if (prev && !uart_tx) falls++;
    prev = uart_tx;
    check("ovf_clear_status", status_word, 32'h0000_0403);
    guard = 0;
    while (tx_busy && guard < 8 * FRAME_CYC) begin
      step(1);
      if (prev && !uart_tx) falls++;
      prev = uart_tx;
      guard++;
    end
    check("ovf_drain_busy", {31'b0, tx_busy}, 32'd0);
    check("ovf_frames", falls, 32'd5);
    check("ovf_final_status", status_word, 32'd0);
    step(2);

    // Address decode: neighbouring addresses do nothing
    store(32'h0000_2008, $urandom());
    check("dec_2008_status", status_word, 32'd0);
    store(32'h0000_1FFC, $urandom());
    check("dec_1ffc_status", status_word, 32'd0);
    step(3);
    check("dec_status", status_word, 32'd0);
    check("dec_tx", {31'b0, uart_tx}, 32'd1);

    // Reset during data bit 3 of a 00 frame with another byte queued
    store(A_DATA, 32'h0000_0000);
    store(A_DATA, 32'h0000_0055);
    step(17);
    check("pre_reset_tx", {31'b0, uart_tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_reset_tx", {31'b0, uart_tx}, 32'd1);
    check("mid_reset_busy", {31'b0, tx_busy}, 32'd0);
    check("mid_reset_status", status_word, 32'd0);
    step(2);
    reset_n = 1'b1;
    lows   = 0;
    busies = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      step(1);
      if (!uart_tx) lows++;
      if (tx_busy) busies++;
    end
    check("post_reset_low_cycles", lows, 32'd0);
    check("post_reset_busy_cycles", busies, 32'd0);
    check("post_reset_status", status_word, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
